div_seq_param: RTL

Parametrised multi-cycle restoring divider and the next-generation replacement for the current 32-bit divider in the MIPS datapath. It supports WIDTH-bit operands and both signed (DIV) and unsigned (DIVU) modes, with a start/done handshake to the control unit. It also flags divide-by-zero. The remainder goes to resultHigh (HI) and the quotient to resultLow (LO).

---
 rtl/div_pkg.sv | 12 +
 rtl/div_step.sv | 31 +++
 rtl/div_seq_param.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } div_state_e;

   localparam int DIV_WIDTH_DEF = 32;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF
) (
   input  logic [WIDTH-1:0] rem,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);

   logic [WIDTH:0]   shifted_s;
   logic [WIDTH-1:0] sub_s;

   // Trial subtraction: the (WIDTH+1)-bit shifted remainder is compared with the divisor.
   // When the trial is non-negative, the difference is below the divisor and fits in WIDTH bits.
   always_comb begin
      shifted_s = {rem, dvd_msb};
      if (shifted_s >= {1'b0, divisor}) begin
         q_bit = 1'b1;
         sub_s = divisor;
      end else begin
         q_bit = 1'b0;
         sub_s = '0;
      end
      rem_next = shifted_s[WIDTH-1:0] - sub_s;
   end

endmodule

// File: rtl/div_seq_param.sv
// Multi-cycle signed/unsigned restoring divider: quotient on resultLow, remainder on resultHigh.
// Define DIV_EARLY_OUT_EN to finish in two cycles whenever |A| < |B|.
module div_seq_param
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Signed,
   input  logic             DivIn,
   output logic             Busy,
   output logic             DivStop,
   output logic             DivZero,
   output logic [WIDTH-1:0] resultHigh,
   output logic [WIDTH-1:0] resultLow
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   div_state_e       state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] rem_r, dvd_r, dvs_r;
   logic             q_neg_r, r_neg_r, zero_r;
   logic             busy_r, stop_r, divzero_r;
   logic [WIDTH-1:0] res_hi_r, res_lo_r;
   logic [WIDTH-1:0] a_mag_s, b_mag_s, step_rem_s;
   logic             a_neg_s, b_neg_s, b_zero_s, early_s, step_q_s;

   assign a_neg_s  = Signed & A[WIDTH-1];
   assign b_neg_s  = Signed & B[WIDTH-1];
   assign a_mag_s  = a_neg_s ? (~A + WIDTH'(1)) : A;
   assign b_mag_s  = b_neg_s ? (~B + WIDTH'(1)) : B;
   assign b_zero_s = (B == '0);

`ifdef DIV_EARLY_OUT_EN
   assign early_s = ~b_zero_s & (a_mag_s < b_mag_s);
`else
   assign early_s = 1'b0;
`endif

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_r),
      .dvd_msb  (dvd_r[WIDTH-1]),
      .divisor  (dvs_r),
      .rem_next (step_rem_s),
      .q_bit    (step_q_s)
   );

   // State register.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) state_r <= IDLE;
      else        state_r <= state_nxt_s;
   end

   // Next-state logic; FIX lasts two cycles: result capture, then the DivStop cycle.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (DivIn) state_nxt_s = (b_zero_s | early_s) ? FIX : CALC;
            else       state_nxt_s = IDLE;
         end
         CALC: begin
            if (cnt_r == CNT_W'(1)) state_nxt_s = FIX;
            else                    state_nxt_s = CALC;
         end
         FIX: begin
            if (stop_r) state_nxt_s = IDLE;
            else        state_nxt_s = FIX;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Datapath: operand latch, shift/subtract iterations, sign fix-up and result registers.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         cnt_r     <= '0;
         rem_r     <= '0;
         dvd_r     <= '0;
         dvs_r     <= '0;
         q_neg_r   <= 1'b0;
         r_neg_r   <= 1'b0;
         zero_r    <= 1'b0;
         busy_r    <= 1'b0;
         stop_r    <= 1'b0;
         divzero_r <= 1'b0;
         res_hi_r  <= '0;
         res_lo_r  <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (DivIn) begin
                  cnt_r     <= CNT_W'(WIDTH);
                  dvs_r     <= b_mag_s;
                  q_neg_r   <= a_neg_s ^ b_neg_s;
                  r_neg_r   <= a_neg_s;
                  zero_r    <= b_zero_s;
                  busy_r    <= 1'b1;
                  divzero_r <= 1'b0;
                  // Early out leaves the dividend as the remainder and a zero quotient.
                  if (early_s) begin
                     rem_r <= a_mag_s;
                     dvd_r <= '0;
                  end else begin
                     rem_r <= '0;
                     dvd_r <= a_mag_s;
                  end
               end
            end
            CALC: begin
               rem_r <= step_rem_s;
               dvd_r <= {dvd_r[WIDTH-2:0], step_q_s};
               cnt_r <= cnt_r - CNT_W'(1);
            end
            FIX: begin
               if (!stop_r) begin
                  stop_r    <= 1'b1;
                  divzero_r <= zero_r;
                  if (zero_r) begin
                     res_lo_r <= '0;
                     res_hi_r <= '0;
                  end else begin
                     res_lo_r <= q_neg_r ? (~dvd_r + WIDTH'(1)) : dvd_r;
                     res_hi_r <= r_neg_r ? (~rem_r + WIDTH'(1)) : rem_r;
                  end
               end else begin
                  stop_r <= 1'b0;
                  busy_r <= 1'b0;
               end
            end
            default: begin
               stop_r <= 1'b0;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign Busy       = busy_r;
   assign DivStop    = stop_r;
   assign DivZero    = divzero_r;
   assign resultHigh = res_hi_r;
   assign resultLow  = res_lo_r;

endmodule
